// File: rtl/edge_buffer_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | edge_buffer_arbiter: round-robin readout of single-shot capture registers |
// | Optional all-channel flush with EDGE_ARB_FLUSH_EN.          Rev 1.0       |
// +--------------------------------------------------------------------------+
module edge_buffer_arbiter #(
  parameter int NCH      = 8,
  parameter int BITWIDTH = 24,
  parameter int CHW      = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [NCH-1:0]          avail,
  input  logic [NCH*BITWIDTH-1:0] q_bus,
  output logic [NCH-1:0]          clear,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BITWIDTH-1:0]     out_data,
  output logic [CHW-1:0]          out_channel,
  output logic [15:0]             word_count
`ifdef EDGE_ARB_FLUSH_EN
  ,
  input  logic                    flush
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    CLEAR   = 2'd2
`ifdef EDGE_ARB_FLUSH_EN
    ,
    FLUSH   = 2'd3
`endif
  } state_t;

  state_t              state_q, state_d;
  logic [CHW-1:0]      last_q, last_d;
  logic [CHW-1:0]      chan_q, chan_d;
  logic [BITWIDTH-1:0] data_q, data_d;
  logic                valid_q, valid_d;
  logic [NCH-1:0]      clear_q, clear_d;
  logic [15:0]         count_q, count_d;

  logic                grant_found;
  logic [CHW-1:0]      grant_ch;
  logic [BITWIDTH-1:0] grant_data;
  int                  cand;

  // First available channel searching upward from last+1, wrapping at NCH.
  always_comb begin
    grant_found = 1'b0;
    grant_ch    = '0;
    grant_data  = '0;
    cand        = 0;
    for (int i = 1; i <= NCH; i++) begin
      cand = int'(last_q) + i;
      if (cand >= NCH) cand = cand - NCH;
      if (!grant_found && avail[cand]) begin
        grant_found = 1'b1;
        grant_ch    = CHW'(cand);
        grant_data  = q_bus[cand*BITWIDTH +: BITWIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    chan_d  = chan_q;
    data_d  = data_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (enable && grant_found) begin
          state_d = PRESENT;
          last_d  = grant_ch;
          chan_d  = grant_ch;
          data_d  = grant_data;
        end
      end
      PRESENT: begin
        if (out_ready) begin
          state_d = CLEAR;
          count_d = count_q + 16'd1;
        end
      end
      CLEAR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef EDGE_ARB_FLUSH_EN
    // Flush overrides any grant or handshake decided above.
    if (flush && state_q != FLUSH) begin
      state_d = FLUSH;
      last_d  = last_q;
      chan_d  = chan_q;
      data_d  = data_q;
      count_d = count_q;
    end
`endif

    // Outputs are registered from the next state so they are glitch-free.
    valid_d = (state_d == PRESENT);
    clear_d = '0;
    for (int i = 0; i < NCH; i++) begin
      clear_d[i] = (state_d == CLEAR) && (chan_d == CHW'(i));
    end
`ifdef EDGE_ARB_FLUSH_EN
    if (state_d == FLUSH) clear_d = '1;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= CHW'(NCH - 1);
      chan_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      clear_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      chan_q  <= chan_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      clear_q <= clear_d;
      count_q <= count_d;
    end
  end

  assign clear       = clear_q;
  assign out_valid   = valid_q;
  assign out_data    = data_q;
  assign out_channel = chan_q;
  assign word_count  = count_q;

endmodule
`default_nettype wire

// File: tb/tb_edge_buffer_arbiter.sv
`default_nettype none
// tb_edge_buffer_arbiter: directed and randomized checks of edge_buffer_arbiter
// against a transaction-level reference model with a capture-register model.
module tb_edge_buffer_arbiter;
  localparam int NCH = 8;
  localparam int BW  = 24;
  localparam int CHW = 3;

  logic              clock     = 1'b0;
  logic              reset     = 1'b1;
  logic              enable    = 1'b0;
  logic              out_ready = 1'b0;
  logic              flush     = 1'b0;
  logic [NCH-1:0]    avail_r   = '0;
  logic [NCH-1:0]    refill    = '0;
  logic [NCH*BW-1:0] q_bus     = '0;
  logic [NCH-1:0]    clear;
  logic              out_valid;
  logic [BW-1:0]     out_data;
  logic [CHW-1:0]    out_channel;
  logic [15:0]       word_count;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: phase 0 idle, 1 word presented, 2 clearing, 3 flushing.
  int             ph      = 0;
  int             m_last  = NCH - 1;
  int             m_ch    = 0;
  logic [BW-1:0]  m_data  = '0;
  logic [15:0]    m_count = '0;
  logic [NCH-1:0] m_clear = '0;

  int   grants[$];
  logic prev_valid = 1'b0;

  edge_buffer_arbiter #(.NCH(NCH), .BITWIDTH(BW), .CHW(CHW)) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .avail       (avail_r),
    .q_bus       (q_bus),
    .clear       (clear),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_channel (out_channel),
    .word_count  (word_count)
`ifdef EDGE_ARB_FLUSH_EN
    ,
    .flush       (flush)
`endif
  );

  always #5 clock = ~clock;

  // Capture registers: set by refill, synchronous clear wins.
  always @(posedge clock) avail_r <= (avail_r | refill) & ~clear;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(logic [NCH-1:0] av, int last);
    for (int i = 1; i <= NCH; i++) begin
      if (av[(last + i) % NCH]) return (last + i) % NCH;
    end
    return -1;
  endfunction

  task automatic model_step(logic r, logic en, logic rdy, logic fl,
                            logic [NCH-1:0] av, logic [NCH*BW-1:0] q);
    int c;
    m_clear = '0;
    if (r) begin
      ph = 0; m_last = NCH - 1; m_ch = 0; m_data = '0; m_count = '0;
    end else if (fl && ph != 3) begin
      ph = 3; m_clear = '1;
    end else begin
      case (ph)
        0: begin
          c = rr_pick(av, m_last);
          if (en && c >= 0) begin
            ph = 1; m_ch = c; m_last = c; m_data = q[c*BW +: BW];
          end
        end
        1: if (rdy) begin
          ph = 2; m_count = m_count + 16'd1; m_clear[m_ch] = 1'b1;
        end
        default: ph = 0;
      endcase
    end
  endtask

  task automatic tick();
    logic [NCH-1:0]    av;
    logic [NCH*BW-1:0] q;
    logic              r, e, rd, fl;
    av = avail_r; q = q_bus; r = reset; e = enable; rd = out_ready; fl = flush;
    @(posedge clock);
    model_step(r, e, rd, fl, av, q);
    #1;
    check("out_valid", 32'(out_valid), 32'(ph == 1));
    check("out_channel", 32'(out_channel), 32'(m_ch));
    check("out_data", 32'(out_data), 32'(m_data));
    check("clear", 32'(clear), 32'(m_clear));
    check("word_count", 32'(word_count), 32'(m_count));
    if (out_valid && !prev_valid) grants.push_back(int'(out_channel));
    prev_valid = out_valid;
  endtask

  initial begin
    logic [BW-1:0] held;
    logic [15:0]   cnt0;

    // Reset state
    reset = 1'b1;
    tick(); tick();
    check("rst_valid", 32'(out_valid), 0);
    check("rst_clear", 32'(clear), 0);
    check("rst_count", 32'(word_count), 0);
    check("rst_data", 32'(out_data), 0);

    // Single word from channel 2
    reset = 1'b0; enable = 1'b1; out_ready = 1'b1;
    q_bus[2*BW +: BW] = 24'hABCDEF;
    refill = 8'h04; tick(); refill = '0;
    tick();
    check("t1_valid", 32'(out_valid), 1);
    check("t1_data", 32'(out_data), 32'h00ABCDEF);
    check("t1_chan", 32'(out_channel), 2);
    tick();
    check("t1_clear", 32'(clear), 32'h04);
    check("t1_valid_low", 32'(out_valid), 0);
    tick();
    check("t1_count", 32'(word_count), 1);
    tick();
    check("t1_no_regrant", 32'(out_valid), 0);

    // All channels continuously available: fairness and throughput
    reset = 1'b1; tick(); reset = 1'b0;
    grants.delete();
    refill = '1;
    repeat (27) tick();
    check("t2_count", 32'(word_count), 9);
    check("t2_ngrants", 32'(grants.size()), 9);
    for (int i = 0; i < 9 && i < grants.size(); i++) begin
      check("t2_order", 32'(grants[i]), 32'(i % NCH));
    end
    refill = '0;
    repeat (40) tick();

    // Backpressure on channel 5
    for (int i = 0; i < NCH; i++) q_bus[i*BW +: BW] = BW'($urandom);
    out_ready = 1'b0;
    refill = 8'h20; tick(); refill = '0;
    tick();
    check("t3_chan", 32'(out_channel), 5);
    check("t3_data", 32'(out_data), 32'(q_bus[5*BW +: BW]));
    held = out_data;
    repeat (10) begin
      tick();
      check("t3_hold_valid", 32'(out_valid), 1);
      check("t3_hold_data", 32'(out_data), 32'(held));
      check("t3_hold_chan", 32'(out_channel), 5);
      check("t3_hold_clear", 32'(clear), 0);
    end
    out_ready = 1'b1;
    tick();
    check("t3_clear", 32'(clear), 32'h20);
    tick();
    check("t3_clear_done", 32'(clear), 0);

    // Enable gating
    enable = 1'b0;
    refill = 8'h01; tick(); refill = '0;
    repeat (20) begin
      tick();
      check("t4_blocked", 32'(out_valid), 0);
    end
    enable = 1'b1;
    tick();
    check("t4_grant", 32'(out_valid), 1);
    check("t4_chan", 32'(out_channel), 0);
    tick(); tick();

    // Reset while a word is presented
    out_ready = 1'b0;
    refill = 8'h18; tick(); refill = '0;
    tick();
    check("t5_pre_chan", 32'(out_channel), 3);
    reset = 1'b1; tick(); reset = 1'b0;
    check("t5_valid", 32'(out_valid), 0);
    check("t5_clear", 32'(clear), 0);
    check("t5_count", 32'(word_count), 0);
    out_ready = 1'b1;
    tick();
    check("t5_regrant", 32'(out_valid), 1);
    check("t5_lowest", 32'(out_channel), 3);
    repeat (10) tick();

`ifdef EDGE_ARB_FLUSH_EN
    // Flush during a presented word with ready high
    refill = 8'h02; tick(); refill = '0;
    tick();
    check("t6_valid", 32'(out_valid), 1);
    cnt0 = word_count;
    flush = 1'b1; out_ready = 1'b1;
    tick(); flush = 1'b0;
    check("t6_clear_all", 32'(clear), 32'hFF);
    check("t6_valid_low", 32'(out_valid), 0);
    check("t6_count", 32'(word_count), 32'(cnt0));
    tick();
    check("t6_idle_clear", 32'(clear), 0);
`else
    cnt0 = word_count;
    check("t6_count_stable", 32'(word_count), 32'(cnt0));
`endif

    // Randomized traffic against the reference model
    repeat (600) begin
      for (int i = 0; i < NCH; i++) q_bus[i*BW +: BW] = BW'($urandom);
      refill    = ($urandom_range(0, 3) == 0) ? NCH'($urandom) : '0;
      out_ready = ($urandom_range(0, 9) < 7);
      enable    = ($urandom_range(0, 19) != 0);
      reset     = ($urandom_range(0, 99) == 0);
`ifdef EDGE_ARB_FLUSH_EN
      flush     = ($urandom_range(0, 49) == 0);
`endif
      tick();
    end
    reset = 1'b0; flush = 1'b0; refill = '0; out_ready = 1'b1; enable = 1'b1;
    repeat (40) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
